// File: rtl/risc16_pkg.sv
// Shared risc16 definitions: instruction geometry and the program loader state encoding.
package risc16;

    localparam int INSTR_WIDTH      = 16;
    localparam int INSTR_PTR_WIDTH  = 8;
    localparam int LOADER_LEN_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DAT_HI = 3'd3,
        DAT_LO = 3'd4,
        WRITE  = 3'd5,
        CSUM   = 3'd6,
        ERR    = 3'd7
    } loader_state_t;

endpackage

// File: rtl/instr_loader.sv
// Byte-stream program loader: assembles big-endian words and writes them into the fetch RAM.
// Optional trailing XOR checksum is compiled in with `define INSTR_LOADER_CHECKSUM_EN.
module instr_loader
    import risc16::*;
#(
    parameter int INSTR_W = INSTR_WIDTH,
    parameter int PTR_W   = INSTR_PTR_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [7:0]         s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic [INSTR_W-1:0] ram_data_o,
    output logic [PTR_W-1:0]   ram_addr_o,
    output logic               ram_we_o,
    output logic               core_hold_o,
    output logic               done_o,
    output logic               err_o,
    output logic [PTR_W:0]     words_o
);

    localparam logic [16:0] CAP_WORDS = 17'd1 << PTR_W;

    loader_state_t      state_r;
    loader_state_t      next_state_s;
    logic               hs_s;
    logic               done_set_s;
    logic [15:0]        len_next_s;
    logic [PTR_W:0]     words_inc_s;
    logic [7:0]         len_hi_r;
    logic [15:0]        len_r;
    logic [7:0]         hi_r;
    logic               s_ready_r;
    logic [INSTR_W-1:0] ram_data_r;
    logic [PTR_W-1:0]   addr_r;
    logic               we_r;
    logic               hold_r;
    logic               done_r;
    logic               err_r;
    logic [PTR_W:0]     words_r;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]         csum_r;
`endif

    assign hs_s        = s_valid_i & s_ready_r;
    assign len_next_s  = {len_hi_r, s_data_i};
    assign words_inc_s = words_r + (PTR_W+1)'(1);

    // Next-state decode; done_set_s marks a successful end of session.
    always_comb begin
        next_state_s = state_r;
        done_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) next_state_s = LEN_HI;
                else         next_state_s = IDLE;
            end
            LEN_HI: begin
                if (hs_s) next_state_s = LEN_LO;
                else      next_state_s = LEN_HI;
            end
            LEN_LO: begin
                if (!hs_s) begin
                    next_state_s = LEN_LO;
                end else if (len_next_s == 16'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    next_state_s = CSUM;
`else
                    next_state_s = IDLE;
                    done_set_s   = 1'b1;
`endif
                end else if ({1'b0, len_next_s} > CAP_WORDS) begin
                    next_state_s = ERR;
                end else begin
                    next_state_s = DAT_HI;
                end
            end
            DAT_HI: begin
                if (hs_s) next_state_s = DAT_LO;
                else      next_state_s = DAT_HI;
            end
            DAT_LO: begin
                if (hs_s) next_state_s = WRITE;
                else      next_state_s = DAT_LO;
            end
            WRITE: begin
                if (17'(words_inc_s) < {1'b0, len_r}) begin
                    next_state_s = DAT_HI;
                end else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    next_state_s = CSUM;
`else
                    next_state_s = IDLE;
                    done_set_s   = 1'b1;
`endif
                end
            end
            CSUM: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                if (!hs_s) begin
                    next_state_s = CSUM;
                end else if (s_data_i == csum_r) begin
                    next_state_s = IDLE;
                    done_set_s   = 1'b1;
                end else begin
                    next_state_s = ERR;
                end
`else
                next_state_s = IDLE;
`endif
            end
            ERR:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            len_hi_r   <= 8'd0;
            len_r      <= 16'd0;
            hi_r       <= 8'd0;
            s_ready_r  <= 1'b0;
            ram_data_r <= '0;
            addr_r     <= '0;
            we_r       <= 1'b0;
            hold_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            words_r    <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_r     <= 8'd0;
`endif
        end else begin
            state_r   <= next_state_s;
            s_ready_r <= (next_state_s == LEN_HI) || (next_state_s == LEN_LO) ||
                         (next_state_s == DAT_HI) || (next_state_s == DAT_LO) ||
                         (next_state_s == CSUM);
            we_r      <= (next_state_s == WRITE);
            hold_r    <= (next_state_s != IDLE);
            done_r    <= done_set_s;
            if (state_r == IDLE && start_i) begin
                err_r   <= 1'b0;
                words_r <= '0;
                addr_r  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum_r  <= 8'd0;
`endif
            end
            if (next_state_s == ERR) err_r <= 1'b1;
            if (state_r == LEN_HI && hs_s) len_hi_r <= s_data_i;
            if (state_r == LEN_LO && hs_s) len_r <= len_next_s;
            if (state_r == DAT_HI && hs_s) hi_r <= s_data_i;
            if (state_r == DAT_LO && hs_s) ram_data_r <= {hi_r, s_data_i};
`ifdef INSTR_LOADER_CHECKSUM_EN
            if ((state_r == DAT_HI || state_r == DAT_LO) && hs_s) csum_r <= csum_r ^ s_data_i;
`endif
            // Address advances after the write cycle, so it wraps to 0 after a full RAM.
            if (state_r == WRITE) begin
                addr_r  <= addr_r + PTR_W'(1);
                words_r <= words_inc_s;
            end
        end
    end

    assign s_ready_o   = s_ready_r;
    assign ram_data_o  = ram_data_r;
    assign ram_addr_o  = addr_r;
    assign ram_we_o    = we_r;
    assign core_hold_o = hold_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign words_o     = words_r;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a write scoreboard; define INSTR_LOADER_CHECKSUM_EN to cover the checksum build.
module tb_instr_loader;

    localparam int PW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [7:0]    s_data_i = 8'h00;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [15:0]   ram_data_o;
    logic [PW-1:0] ram_addr_o;
    logic          ram_we_o;
    logic          core_hold_o;
    logic          done_o;
    logic          err_o;
    logic [PW:0]   words_o;

    int            n_assert = 0;
    int            n_fail = 0;
    int            done_cnt = 0;
    int            we_cnt = 0;
    int            exp_addr = 0;
    logic [23:0]   exp_q[$];
    logic [15:0]   words_q[$];

    instr_loader #(.INSTR_W(16), .PTR_W(PW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .ram_data_o(ram_data_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
        .core_hold_o(core_hold_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; every write seen is popped against the scoreboard.
    task automatic tick();
        logic [23:0] e;
        @(posedge clk_i);
        #1;
        if (ram_we_o === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(ram_addr_o), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(ram_addr_o), 32'(e[23:16]));
                chk("write_data", 32'(ram_data_o), 32'(e[15:0]));
            end
        end
        if (done_o === 1'b1) done_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int k = 0;
        s_data_i = b;
        if (gap) begin
            s_valid_i = 1'b0;
            tick();
        end
        s_valid_i = 1'b1;
        while (s_ready_o !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) chk("ready_timeout", 32'(k), 32'd0);
        tick();
        s_valid_i = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (core_hold_o === 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk("hold_fall_timeout", 32'(k < 100), 32'd1);
    endtask

    task automatic do_start();
        done_cnt = 0;
        we_cnt   = 0;
        exp_addr = 0;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        chk("start_hold", 32'(core_hold_o), 32'd1);
        chk("start_ready", 32'(s_ready_o), 32'd1);
    endtask

    // Full session over words_q with optional gaps, start collision and checksum corruption.
    task automatic session(input logic [15:0] n, input bit gap, input bit collide, input logic [7:0] cs_delta);
        logic [7:0] cs = 8'h00;
        logic [15:0] w;
        do_start();
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        if (collide) begin
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
        end
        for (int i = 0; i < words_q.size(); i++) begin
            w = words_q[i];
            cs = cs ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8], gap);
            exp_q.push_back({8'(exp_addr), w});
            exp_addr++;
            send_byte(w[7:0], gap);
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(cs ^ cs_delta, gap);
`else
        if (cs_delta != 8'h00) cs = 8'h00;
`endif
        wait_end();
    endtask

    task automatic check_ok(input string tag, input int nw);
        chk({tag, "_words"}, 32'(words_o), 32'(nw));
        chk({tag, "_we_count"}, 32'(we_cnt), 32'(nw));
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        tick();
        chk({tag, "_done_pulse_len"}, 32'(done_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(s_ready_o), 32'd0);
        chk({tag, "_we"}, 32'(ram_we_o), 32'd0);
        chk({tag, "_data"}, 32'(ram_data_o), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr_o), 32'd0);
        chk({tag, "_hold"}, 32'(core_hold_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_words"}, 32'(words_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        #1;
        tick();
        check_reset_outputs("reset");
        rst_i = 1'b0;
        tick();
        tick();

        // Normal load, valid held high
        words_q = '{16'h1234, 16'hABCD, 16'h0001};
        session(16'd3, 1'b0, 1'b0, 8'h00);
        check_ok("normal", 3);

        // Gapped stream with a start collision mid-session
        session(16'd3, 1'b1, 1'b1, 8'h00);
        check_ok("gapped", 3);

        // Zero length
        words_q = {};
        session(16'd0, 1'b0, 1'b0, 8'h00);
        check_ok("zero_len", 0);

        // Oversize length
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        wait_end();
        chk("oversize_err", 32'(err_o), 32'd1);
        chk("oversize_we_count", 32'(we_cnt), 32'd0);
        chk("oversize_done", 32'(done_cnt), 32'd0);
        chk("oversize_hold", 32'(core_hold_o), 32'd0);
        tick();
        chk("oversize_err_sticky", 32'(err_o), 32'd1);

        // Full RAM: every address once, then nothing more
        words_q = {};
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            words_q.push_back({b, ~b});
        end
        session(16'd256, 1'b0, 1'b0, 8'h00);
        check_ok("full", 256);
        for (int i = 0; i < 5; i++) tick();
        chk("full_no_extra_write", 32'(we_cnt), 32'd256);

        // Reset after the third data byte
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h12, 1'b0);
        exp_q.push_back({8'h00, 16'h1234});
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b0);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midreset");
        tick();
        rst_i = 1'b0;
        s_valid_i = 1'b1;
        tick();
        s_valid_i = 1'b0;
        chk("midreset_idle_ready", 32'(s_ready_o), 32'd0);
        chk("midreset_idle_hold", 32'(core_hold_o), 32'd0);
        chk("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
        words_q = '{16'h1234, 16'hABCD, 16'h0001};
        session(16'd3, 1'b0, 1'b0, 8'h00);
        check_ok("after_reset", 3);

`ifdef INSTR_LOADER_CHECKSUM_EN
        words_q = '{16'h1234};
        session(16'd1, 1'b0, 1'b0, 8'h00);
        check_ok("csum_match", 1);
        session(16'd1, 1'b0, 1'b0, 8'h01);
        chk("csum_bad_err", 32'(err_o), 32'd1);
        chk("csum_bad_done", 32'(done_cnt), 32'd0);
        chk("csum_bad_words", 32'(words_o), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Write-side counterpart of the instruction fetch stage. It receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. Each word is written into the write port of the instruction dual-port RAM at consecutive addresses starting at 0. While a load is in progress, `core_hold_o` keeps the core held so that fetch never reads a partially written program.

## Interface
- `INSTR_W`, default `INSTR_WIDTH` (16): instruction word width; fixed at 2 bytes.
- `PTR_W`, default `INSTR_PTR_WIDTH`: RAM address width; capacity is 2^PTR_W words.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: one-cycle pulse that opens a load session; ignored while busy.
- `s_data_i` in 8: stream byte.
- `s_valid_i` in 1: `s_data_i` is valid.
- `s_ready_o` out 1: loader accepts the byte this cycle.
- `ram_data_o` out INSTR_W: write data to the RAM `data` port.
- `ram_addr_o` out PTR_W: write address to the RAM `write_addr` port.
- `ram_we_o` out 1: write enable to the RAM `we` port.
- `core_hold_o` out 1: high from `start_i` until the session ends.
- `done_o` out 1: one-cycle pulse when a session ends successfully.
- `err_o` out 1: sticky error flag; cleared by the next accepted `start_i`.
- `words_o` out PTR_W+1: number of words written in the current or last session.

## Operation
- Stream format:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N × (HI byte, LO byte).
  - CSUM byte, only when the checksum feature is compiled in.
- FSM states: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CSUM, ERR.
- IDLE:
  - On `start_i`: clear `err_o`, `words_o` and the address counter; go to LEN_HI.
  - `start_i` in any other state is ignored.
- LEN_HI -> LEN_LO: each transition happens on a handshake (`s_valid_i & s_ready_o`).
- LEN_LO, on handshake:
  - N = 0: end session; go to CSUM if enabled, else to IDLE with a `done_o` pulse.
  - N > 2^PTR_W: go to ERR.
  - Otherwise: go to DAT_HI.
- DAT_HI -> DAT_LO on handshake; the high byte is latched.
- DAT_LO -> WRITE on handshake; `ram_data_o` = {hi, lo}.
- WRITE (exactly one cycle):
  - `ram_we_o`=1, `ram_addr_o` = address counter.
  - Then increment the address counter and `words_o`.
  - Next state: DAT_HI if `words_o` (post-increment) < N, else end of session as above.
- ERR: one cycle; `err_o` set; go to IDLE. No pulse on `done_o`.
- `s_ready_o` = 1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO and CSUM. It is 0 in IDLE, WRITE and ERR; bytes offered then are not consumed.
- `core_hold_o` = 1 in every state except IDLE.
- Address arithmetic: the counter is PTR_W bits. N = 2^PTR_W fills the RAM exactly; the final increment wraps the counter to 0 with no further write.
- Reset mid-session: state -> IDLE, all outputs -> reset values. RAM contents are left as they are, since the loader cannot clear them.

## Timing
- Reset values:
  - `s_ready_o`=0, `ram_we_o`=0, `ram_data_o`=0, `ram_addr_o`=0.
  - `core_hold_o`=0, `done_o`=0, `err_o`=0, `words_o`=0.
- All outputs are registered or decoded directly from state; there is no combinational path from `s_valid_i` to `s_ready_o`.
- `start_i` at cycle t: `core_hold_o`=1 and `s_ready_o`=1 at t+1.
- Word write: `ram_we_o` is asserted in the cycle after the LO-byte handshake. Maximum throughput is 1 word per 3 cycles.
- `done_o` is asserted one cycle after the final WRITE, or after the final CSUM handshake. `core_hold_o` falls in that same cycle.
- RAM write-to-read: the program is readable by fetch at least 1 cycle after `core_hold_o` falls.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - The loader keeps a running XOR of all payload bytes (excluding the length bytes).
  - After the last word it enters CSUM and accepts one byte.
  - Match: `done_o` pulse.
  - Mismatch: ERR. Words already written remain in RAM.
- `INSTR_LOADER_CHECKSUM_EN` undefined: the CSUM state and the XOR register are absent; the session ends after the last WRITE.

## Structure
- In package `risc16`:
  - `loader_state_t` enum.
  - `LOADER_LEN_BYTES` = 2.
  - `INSTR_WIDTH` and `INSTR_PTR_WIDTH`, which already live there.
- Single module, no sub-module.
- The top level connects the `ram_*` outputs to the write port of the fetch-stage `dp_ram` and connects `core_hold_o` into fetch-stage reset/stall.

## Test plan
- **Normal load:** `start_i`, then bytes 00 03 12 34 AB CD 00 01, `s_valid_i` held high.
  - Writes: 0x1234@0, 0xABCD@1, 0x0001@2.
  - `words_o`=3, `done_o` pulse, `err_o`=0.
- **Backpressure and gaps:** same stream with `s_valid_i` toggled every other cycle.
  - Identical writes; `ram_we_o` never asserted twice for one word.
- **Zero and oversize length:**
  - N=0x0000: `done_o` with no `ram_we_o`.
  - N=2^PTR_W+1: `err_o`=1, no writes, `core_hold_o` falls.
- **Full RAM:** N=2^PTR_W.
  - The last write is at address 2^PTR_W−1, `words_o`=2^PTR_W, and no write occurs at address 0 after it.
- **Reset and start collisions:**
  - `rst_i` pulse after the 3rd data byte: all outputs 0, state IDLE.
  - A new session then loads correctly.
  - `start_i` asserted while busy has no effect.
- **Checksum (`INSTR_LOADER_CHECKSUM_EN`):**
  - Stream 00 01 12 34 then 26: `done_o`.
  - Trailing 27 instead: `err_o`=1 and no `done_o`.
